// File: rtl/sync_fifo_param.sv
// -----------------------------------------------------------------------------
// sync_fifo_param
//
// Parametrised single-clock synchronous FIFO. Holds the full DEPTH entries,
// accepts one write and one read per cycle (also together), and presents read
// data from a register together with a one-cycle valid strobe. Adds an
// occupancy count, almost-full/almost-empty thresholds and sticky
// overflow/underflow error flags. Storage is an inferred memory array.
//
// Parameters
//   WIDTH     data width in bits (>=1)
//   DEPTH     number of entries, power of two, >=4
//   AF_LEVEL  almost_full  when count >= AF_LEVEL (1..DEPTH)
//   AE_LEVEL  almost_empty when count <= AE_LEVEL (0..DEPTH-1)
//
// Ports
//   clk           rising-edge clock for all state
//   rst           synchronous reset, active-high
//   din           write data
//   we_n          write request, active-low, level-sampled
//   oe_n          read request, active-low, level-sampled
//   clr_err       clears overflow/underflow (a new error in the same cycle wins)
//   dout          registered read data, holds when no read is accepted
//   dout_valid    dout was loaded at the last edge
//   count         entries held, 0..DEPTH
//   full, empty   count==DEPTH / count==0
//   almost_full   count >= AF_LEVEL
//   almost_empty  count <= AE_LEVEL
//   overflow      sticky: write requested while full
//   underflow     sticky: read requested while empty
// -----------------------------------------------------------------------------
module sync_fifo_param #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 1024,
    parameter int AF_LEVEL = DEPTH - 4,
    parameter int AE_LEVEL = 4,
    localparam int AW      = $clog2(DEPTH),
    localparam int CW      = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             we_n,
    input  logic             oe_n,
    input  logic             clr_err,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic             overflow,
    output logic             underflow
);

    // Thresholds and increments sized to the registers they are compared with.
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);
    localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

    // Storage (intentionally not reset; pointers and count define validity).
    logic [WIDTH-1:0] mem_q [DEPTH];

    // Registered state.
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             dout_valid_q, dout_valid_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;

    // Combinational status and accept strobes.
    logic full_s;
    logic empty_s;
    logic almost_full_s;
    logic almost_empty_s;
    logic wa_s;
    logic ra_s;

    // Status flags depend only on the count register, never on the requests.
    always_comb begin
        full_s         = (count_q == DEPTH_C);
        empty_s        = (count_q == CNT_ZERO);
        almost_full_s  = (count_q >= AF_C);
        almost_empty_s = (count_q <= AE_C);
    end

    // Accept decisions use the pre-edge flags: a read in the same cycle does
    // not unblock a write that full is holding off.
    always_comb begin
        wa_s = !we_n && !full_s;
        ra_s = !oe_n && !empty_s;
    end

    // Pointer advance; AW-bit pointers wrap naturally modulo DEPTH.
    always_comb begin
        if (wa_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (ra_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
    end

    // Occupancy: a simultaneous read and write cancel out.
    always_comb begin
        case ({wa_s, ra_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Read data path: load on accept, otherwise hold with valid dropped.
    // A same-cycle write never targets rd_ptr because a read implies count>=1.
    always_comb begin
        if (ra_s) begin
            dout_d = mem_q[rd_ptr_q];
        end else begin
            dout_d = dout_q;
        end
        dout_valid_d = ra_s;
    end

    // Sticky error flags; a fresh error outranks clr_err in the same cycle.
    always_comb begin
        if (!we_n && full_s) begin
            overflow_d = 1'b1;
        end else if (clr_err) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
        if (!oe_n && empty_s) begin
            underflow_d = 1'b1;
        end else if (clr_err) begin
            underflow_d = 1'b0;
        end else begin
            underflow_d = underflow_q;
        end
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= {AW{1'b0}};
            rd_ptr_q     <= {AW{1'b0}};
            count_q      <= CNT_ZERO;
            dout_q       <= {WIDTH{1'b0}};
            dout_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            overflow_q   <= overflow_d;
            underflow_q  <= underflow_d;
        end
    end

    // Memory write port; reset suppresses the write so it cannot race the
    // pointer clear.
    always_ff @(posedge clk) begin
        if (wa_s && !rst) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign dout         = dout_q;
    assign dout_valid   = dout_valid_q;
    assign count        = count_q;
    assign full         = full_s;
    assign empty        = empty_s;
    assign almost_full  = almost_full_s;
    assign almost_empty = almost_empty_s;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo_param
//
// Self-checking bench for sync_fifo_param at WIDTH=8, DEPTH=16, AF_LEVEL=12,
// AE_LEVEL=4. A queue-based reference model tracks accepted writes; accepted
// reads pop the expected word, which is compared when dout_valid appears.
// -----------------------------------------------------------------------------
module tb_sync_fifo_param;

    localparam int W = 8;
    localparam int D = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] din = 8'h00;
    logic         we_n = 1'b1;
    logic         oe_n = 1'b1;
    logic         clr_err = 1'b0;
    logic [W-1:0] dout;
    logic         dout_valid;
    logic [4:0]   count;
    logic         full, empty, almost_full, almost_empty, overflow, underflow;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    logic [W-1:0] sb[$];
    int           m_count = 0;
    logic         m_ov = 1'b0;
    logic         m_uf = 1'b0;
    logic         exp_valid = 1'b0;
    logic [W-1:0] exp_dout = 8'h00;
    logic         last_wa = 1'b0;
    logic         last_ra = 1'b0;

    sync_fifo_param #(
        .WIDTH(W), .DEPTH(D), .AF_LEVEL(12), .AE_LEVEL(4)
    ) dut (
        .clk(clk), .rst(rst), .din(din), .we_n(we_n), .oe_n(oe_n),
        .clr_err(clr_err), .dout(dout), .dout_valid(dout_valid),
        .count(count), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    // Drive one cycle of stimulus, wait for the edge, update the model.
    task automatic do_cycle(input logic w_n, input logic o_n, input logic [W-1:0] d,
                            input logic clr, input logic r);
        bit full_pre;
        bit empty_pre;
        we_n = w_n; oe_n = o_n; din = d; clr_err = clr; rst = r;
        full_pre  = (m_count == D);
        empty_pre = (m_count == 0);
        @(posedge clk);
        #1;
        if (r) begin
            sb.delete();
            m_count = 0; m_ov = 1'b0; m_uf = 1'b0;
            exp_valid = 1'b0; exp_dout = 8'h00;
            last_wa = 1'b0; last_ra = 1'b0;
        end else begin
            last_wa = !w_n && !full_pre;
            last_ra = !o_n && !empty_pre;
            if (last_ra) begin
                exp_dout  = sb.pop_front();
                exp_valid = 1'b1;
            end else begin
                exp_valid = 1'b0;
            end
            if (last_wa) sb.push_back(d);
            m_count = sb.size();
            if (!w_n && full_pre) m_ov = 1'b1;
            else if (clr)         m_ov = 1'b0;
            if (!o_n && empty_pre) m_uf = 1'b1;
            else if (clr)          m_uf = 1'b0;
        end
    endtask

    task automatic test_reset();
        do_cycle(1'b1, 1'b1, 8'h00, 1'b0, 1'b1);
        do_cycle(1'b1, 1'b1, 8'h00, 1'b0, 1'b1);
        n_checks++; if (empty !== 1'b1) $display("FAIL reset_empty: got %b want 1", empty); else n_pass++;
        n_checks++; if (almost_empty !== 1'b1) $display("FAIL reset_ae: got %b want 1", almost_empty); else n_pass++;
        n_checks++; if (count !== 5'd0) $display("FAIL reset_count: got %0d want 0", count); else n_pass++;
        n_checks++; if (dout !== 8'h00) $display("FAIL reset_dout: got %h want 00", dout); else n_pass++;
        n_checks++; if (dout_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", dout_valid); else n_pass++;
        n_checks++; if (full !== 1'b0 || almost_full !== 1'b0) $display("FAIL reset_full: got %b%b want 00", full, almost_full); else n_pass++;
        n_checks++; if (overflow !== 1'b0 || underflow !== 1'b0) $display("FAIL reset_err: got %b%b want 00", overflow, underflow); else n_pass++;
    endtask

    task automatic test_fill();
        for (int i = 1; i <= D; i++) begin
            do_cycle(1'b0, 1'b1, 8'(i), 1'b0, 1'b0);
            n_checks++; if (count !== 5'(i)) $display("FAIL fill_count: got %0d want %0d", count, i); else n_pass++;
            n_checks++; if (almost_full !== (i >= 12)) $display("FAIL fill_af: i=%0d got %b", i, almost_full); else n_pass++;
            n_checks++; if (full !== (i == D)) $display("FAIL fill_full: i=%0d got %b", i, full); else n_pass++;
        end
        do_cycle(1'b0, 1'b1, 8'h11, 1'b0, 1'b0);
        n_checks++; if (count !== 5'd16) $display("FAIL ovf_count: got %0d want 16", count); else n_pass++;
        n_checks++; if (overflow !== 1'b1) $display("FAIL ovf_flag: got %b want 1", overflow); else n_pass++;
        // Error condition and clear in the same cycle: the error wins.
        do_cycle(1'b0, 1'b1, 8'h12, 1'b1, 1'b0);
        n_checks++; if (overflow !== 1'b1) $display("FAIL ovf_vs_clr: got %b want 1", overflow); else n_pass++;
    endtask

    task automatic test_drain();
        for (int i = 1; i <= D; i++) begin
            do_cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
            n_checks++; if (dout_valid !== 1'b1) $display("FAIL drain_valid: i=%0d got %b", i, dout_valid); else n_pass++;
            n_checks++; if (dout !== 8'(i)) $display("FAIL drain_dout: got %h want %h", dout, 8'(i)); else n_pass++;
            n_checks++; if (empty !== (i == D)) $display("FAIL drain_empty: i=%0d got %b", i, empty); else n_pass++;
            n_checks++; if (almost_empty !== ((D - i) <= 4)) $display("FAIL drain_ae: i=%0d got %b", i, almost_empty); else n_pass++;
        end
        do_cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        n_checks++; if (underflow !== 1'b1) $display("FAIL udf_flag: got %b want 1", underflow); else n_pass++;
        n_checks++; if (dout_valid !== 1'b0) $display("FAIL udf_valid: got %b want 0", dout_valid); else n_pass++;
        n_checks++; if (dout !== 8'h10) $display("FAIL udf_hold: got %h want 10", dout); else n_pass++;
        do_cycle(1'b1, 1'b1, 8'h00, 1'b1, 1'b0);
        n_checks++; if (overflow !== 1'b0 || underflow !== 1'b0) $display("FAIL clr_err: got %b%b want 00", overflow, underflow); else n_pass++;
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 5; i++) do_cycle(1'b0, 1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            do_cycle(1'b0, 1'b0, 8'hB0 + 8'(i), 1'b0, 1'b0);
            n_checks++; if (count !== 5'd5) $display("FAIL rw_count: got %0d want 5", count); else n_pass++;
            n_checks++; if (dout_valid !== 1'b1 || dout !== exp_dout) $display("FAIL rw_dout: got %b/%h want 1/%h", dout_valid, dout, exp_dout); else n_pass++;
        end
        for (int i = 0; i < 5; i++) begin
            do_cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
            n_checks++; if (dout !== 8'hB5 + 8'(i)) $display("FAIL rw_tail: got %h want %h", dout, 8'hB5 + 8'(i)); else n_pass++;
        end
        n_checks++; if (empty !== 1'b1) $display("FAIL rw_empty: got %b want 1", empty); else n_pass++;
    endtask

    task automatic test_full_both();
        for (int i = 0; i < D; i++) do_cycle(1'b0, 1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0);
        do_cycle(1'b0, 1'b0, 8'hEE, 1'b0, 1'b0);
        n_checks++; if (count !== 5'd15) $display("FAIL fb_count: got %0d want 15", count); else n_pass++;
        n_checks++; if (overflow !== 1'b1) $display("FAIL fb_ovf: got %b want 1", overflow); else n_pass++;
        n_checks++; if (dout_valid !== 1'b1 || dout !== 8'hC0) $display("FAIL fb_dout: got %b/%h want 1/c0", dout_valid, dout); else n_pass++;
        for (int i = 1; i < D; i++) begin
            do_cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
            n_checks++; if (dout !== 8'hC0 + 8'(i)) $display("FAIL fb_drain: got %h want %h", dout, 8'hC0 + 8'(i)); else n_pass++;
        end
        do_cycle(1'b1, 1'b1, 8'h00, 1'b1, 1'b0);
    endtask

    task automatic test_stream();
        int wr_cnt = 0;
        int rd_cnt = 0;
        int cyc    = 0;
        logic w, o;
        while (rd_cnt < 3 * D && cyc < 2000) begin
            w = (wr_cnt < 3 * D && $urandom_range(0, 3) != 0) ? 1'b0 : 1'b1;
            o = ($urandom_range(0, 3) != 0) ? 1'b0 : 1'b1;
            do_cycle(w, o, 8'(wr_cnt), 1'b0, 1'b0);
            cyc++;
            if (last_wa) wr_cnt++;
            n_checks++; if (dout_valid !== exp_valid) $display("FAIL st_valid: cyc=%0d got %b want %b", cyc, dout_valid, exp_valid); else n_pass++;
            if (last_ra) begin
                n_checks++; if (dout !== 8'(rd_cnt)) $display("FAIL st_order: got %h want %h", dout, 8'(rd_cnt)); else n_pass++;
                rd_cnt++;
            end
            n_checks++; if (int'(count) !== m_count) $display("FAIL st_count: got %0d want %0d", count, m_count); else n_pass++;
            n_checks++; if (underflow !== m_uf || overflow !== m_ov) $display("FAIL st_err: got %b%b want %b%b", overflow, underflow, m_ov, m_uf); else n_pass++;
        end
        n_checks++; if (rd_cnt !== 3 * D) $display("FAIL st_timeout: got %0d reads want %0d", rd_cnt, 3 * D); else n_pass++;
    endtask

    task automatic test_reset_midstream();
        for (int i = 0; i < 6; i++) do_cycle(1'b0, 1'b1, 8'h50 + 8'(i), 1'b0, 1'b0);
        do_cycle(1'b0, 1'b0, 8'h77, 1'b0, 1'b1);
        n_checks++; if (count !== 5'd0 || empty !== 1'b1) $display("FAIL mr_state: got %0d/%b want 0/1", count, empty); else n_pass++;
        n_checks++; if (dout_valid !== 1'b0 || dout !== 8'h00) $display("FAIL mr_dout: got %b/%h want 0/00", dout_valid, dout); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            do_cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
            n_checks++; if (dout_valid !== 1'b0) $display("FAIL mr_novalid: got %b want 0", dout_valid); else n_pass++;
            n_checks++; if (count !== 5'd0 || underflow !== 1'b1) $display("FAIL mr_after: got %0d/%b want 0/1", count, underflow); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_simultaneous();
        test_full_both();
        test_stream();
        test_reset_midstream();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
